// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the receiver and intended for the future
// transmitter.
//   uart_state_t : receiver FSM state encoding
//   mid_point()  : mid-bit clock count for a given CYCLES_PER_BIT
//   maj3()       : 3-input majority
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } uart_state_t;

  function automatic int unsigned mid_point(input int unsigned cycles_per_bit);
    return cycles_per_bit / 2;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Input conditioning for the UART receiver: a 2-FF synchroniser on the
// asynchronous serial line, followed by a two-deep history of the synced
// value so that a 3-sample majority is available every cycle.
// Ports:
//   i_Clk  : system clock
//   i_Rst  : asynchronous active-low reset
//   i_Rx   : raw serial line (asynchronous, idle high)
//   o_Rx   : synchronised line (2 cycles of latency)
//   o_Vote : majority of o_Rx over the current and previous two cycles
module uart_rx_sync_vote
  import uart_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Rx,
  output logic o_Rx,
  output logic o_Vote
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist1;
  logic r_hist2;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist1 <= 1'b0;
      r_hist2 <= 1'b0;
    end else begin
      r_sync1 <= i_Rx;
      r_sync2 <= r_sync1;
      r_hist1 <= r_sync2;
      r_hist2 <= r_hist1;
    end
  end

  assign o_Rx = r_sync2;
  // Read when the bit counter sits at MID+1: covers the synced samples
  // taken at counts MID-1, MID and MID+1.
  assign o_Vote = maj3(r_sync2, r_hist1, r_hist2);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver feeding the AES byte assembler.
// Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stops.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit/state).
// Ports:
//   i_Clk        : system clock
//   i_Rst        : asynchronous active-low reset
//   i_Rx         : serial line, asynchronous, idle high
//   o_Data       : last received word, held until the next o_fDone
//   o_fDone      : one-cycle pulse when a frame completes
//   o_fFrameErr  : with o_fDone, a stop bit was sampled low
//   o_fParityErr : with o_fDone, parity mismatch (0 without the macro)
//   o_fBusy      : high whenever the FSM is not idle
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 434,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_ODD     = 0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Rx,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_fDone,
  output logic                 o_fFrameErr,
  output logic                 o_fParityErr,
  output logic                 o_fBusy
);

  localparam int unsigned CW = $clog2(CYCLES_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LP_LAST     = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] LP_SAMPLE   = CW'(mid_point(CYCLES_PER_BIT) + 1);
  localparam logic [BW-1:0] LP_LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          LP_LAST_STOP = 1'(STOP_BITS - 1);

  logic                 w_rx;
  logic                 w_vote;
  logic                 w_wrap;
  logic                 w_sample;

  uart_state_t          r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stopcnt;
  logic                 r_armed;
  logic                 r_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr;
`endif

  uart_rx_sync_vote u_sync_vote (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Rx   (i_Rx),
    .o_Rx   (w_rx),
    .o_Vote (w_vote)
  );

  assign w_wrap   = (r_cnt == LP_LAST);
  assign w_sample = (r_cnt == LP_SAMPLE);
  assign o_fBusy  = (r_state != ST_IDLE);

`ifndef UART_RX_PARITY_EN
  assign o_fParityErr = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_stopcnt   <= 1'b0;
      r_armed     <= 1'b0;
      r_ferr      <= 1'b0;
      o_Data      <= '0;
      o_fDone     <= 1'b0;
      o_fFrameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr       <= 1'b0;
      o_fParityErr <= 1'b0;
`endif
    end else begin
      o_fDone     <= 1'b0;
      o_fFrameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_fParityErr <= 1'b0;
`endif
      // Counter is parked at 0 while idle so START begins at count 0.
      if (r_state == ST_IDLE || w_wrap) r_cnt <= '0;
      else                              r_cnt <= r_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_rx)         r_armed <= 1'b1;
          else if (r_armed) r_state <= ST_START;
        end
        ST_START: begin
          if (w_sample && w_vote) begin
            r_state <= ST_IDLE;
          end else if (w_wrap) begin
            r_state  <= ST_DATA;
            r_bitcnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_sample) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_wrap) begin
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == LP_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state   <= ST_STOP;
              r_stopcnt <= 1'b0;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_sample) r_perr <= w_vote ^ (^r_shift) ^ 1'(PARITY_ODD);
          if (w_wrap) begin
            r_state   <= ST_STOP;
            r_stopcnt <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          // The last stop bit leaves right after its sample instead of at
          // the wrap, so the next start edge is never missed.
          if (w_sample) begin
            if (!w_vote) r_ferr <= 1'b1;
            if (r_stopcnt == LP_LAST_STOP) r_state   <= ST_DONE;
            else                           r_stopcnt <= 1'b1;
          end
        end
        ST_DONE: begin
          o_Data      <= r_shift;
          o_fDone     <= 1'b1;
          o_fFrameErr <= r_ferr;
          // A framing error (e.g. a break) must see the line high again
          // before another start edge is accepted.
          r_armed     <= ~r_ferr;
          r_ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
          o_fParityErr <= r_perr;
          r_perr       <= 1'b0;
`endif
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
